// File: rtl/sr_cmd_driver_if.sv
// ----------------------------------------------------------------------------
// sr_cmd_driver_if
//   Request/response bundle between a requester and sr_cmd_driver.
//
//   req_valid  requester -> driver  a target level is presented on req_level
//   req_level  requester -> driver  target level (1 = set, 0 = reset)
//   req_ready  driver -> requester  driver accepts a request this cycle
//   done       driver -> requester  one-cycle completion strobe
//   mismatch   driver -> requester  qualified by done: readback != target
//
//   modport master : requester side
//   modport slave  : driver side
// ----------------------------------------------------------------------------
interface sr_cmd_driver_if;
  logic req_valid;
  logic req_level;
  logic req_ready;
  logic done;
  logic mismatch;

  modport master (
    output req_valid,
    output req_level,
    input  req_ready,
    input  done,
    input  mismatch
  );

  modport slave (
    input  req_valid,
    input  req_level,
    output req_ready,
    output done,
    output mismatch
  );
endinterface

// File: rtl/sr_cmd_driver.sv
// ----------------------------------------------------------------------------
// sr_cmd_driver
//   Drives an external SR flop to a requested level. A request whose level
//   already matches the readback completes immediately. Otherwise a set or
//   reset pulse is held for PULSE_CYCLES, the flop is left alone for
//   SETTLE_CYCLES, and the readback is then sampled and compared against the
//   target. Any failed readback latches err_sticky until reset.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   req        request/response bundle (slave modport)
//   q_in       readback of the SR flop output
//   s, r       registered set/reset commands to the SR flop
//   err_sticky latched readback failure, cleared only by rst
//   busy       high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module sr_cmd_driver #(
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  sr_cmd_driver_if.slave    req,
  input  logic              q_in,
  output logic              s,
  output logic              r,
  output logic              err_sticky,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Counters hold "cycles remaining minus one" so zero marks the last cycle.
  localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       done_q, done_d;
  logic       mismatch_q, mismatch_d;
  logic       err_q, err_d;

  // State and output registers; reset forces every command and strobe low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      level_q    <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      s_q        <= s_d;
      r_q        <= r_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered, so s/r/done line up with PULSE/RESP cycles exactly.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    s_d        = 1'b0;
    r_d        = 1'b0;
    done_d     = 1'b0;
    mismatch_d = 1'b0;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req.req_valid) begin
          level_d = req.req_level;
          if (req.req_level == q_in) begin
            // Already at target: report success without touching the flop.
            state_d = ST_RESP;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PULSE;
            cnt_d   = PULSE_LOAD;
            // s and r are complementary here, never both high.
            s_d     = req.req_level;
            r_d     = ~req.req_level;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
          s_d   = level_q;
          r_d   = ~level_q;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          // q_in is only looked at on this edge; earlier wiggles are ignored.
          state_d    = ST_RESP;
          done_d     = 1'b1;
          mismatch_d = (q_in != level_q);
          err_d      = err_q | (q_in != level_q);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign req.req_ready = (state_q == ST_IDLE);
  assign req.done      = done_q;
  assign req.mismatch  = mismatch_q;
  assign s             = s_q;
  assign r             = r_q;
  assign err_sticky    = err_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sr_cmd_driver.sv
// ----------------------------------------------------------------------------
// tb_sr_cmd_driver
//   Self-checking bench for sr_cmd_driver (PULSE_CYCLES=2, SETTLE_CYCLES=3).
//   A timing model runs on each rising edge: it decides acceptances from the
//   bench's own notion of idleness, records the expected pulse window and
//   pushes the expected done cycle and mismatch value to a scoreboard queue.
//   A monitor on each falling edge compares every DUT output to the model.
//   A plant model of the SR flop follows s/r and can be forced stuck or
//   glitched.
// ----------------------------------------------------------------------------
module tb_sr_cmd_driver;

  localparam int P = 2;
  localparam int S = 3;

  logic clk;
  logic rst;
  logic q_in;
  logic s;
  logic r;
  logic err_sticky;
  logic busy;

  sr_cmd_driver_if u_if ();

  sr_cmd_driver #(
    .PULSE_CYCLES  (P),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (u_if),
    .q_in       (q_in),
    .s          (s),
    .r          (r),
    .err_sticky (err_sticky),
    .busy       (busy)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plant and stimulus controls
  logic q_m;
  logic stuck_en;
  logic stuck_val;
  logic glitch;
  assign q_in = glitch ^ (stuck_en ? stuck_val : q_m);

  // Scoreboard
  typedef struct {
    int   c;
    logic mis;
  } exp_t;
  exp_t sb[$];

  // Model state
  int   cyc;
  int   m_free;
  int   win_lo;
  int   win_hi;
  logic win_lvl;
  logic m_err;
  logic e_done;
  logic e_mis;
  int   m_accepts;

  int   n_checks;
  int   n_pass;
  int   timeout_cnt;
  logic fin_req;
  logic fin_done;

  // Comparison helper: counts every check and reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // SR flop plant: follows the driver's commands
  initial begin
    q_m = 1'b0;
    forever begin
      @(negedge clk);
      if (s === 1'b1) q_m = 1'b1;
      else if (r === 1'b1) q_m = 1'b0;
    end
  end

  // Reference timing model, evaluated at each rising edge
  initial begin
    exp_t e;
    logic lvl;
    logic fq;
    cyc = 0; m_free = 0; win_lo = 1; win_hi = 0; win_lvl = 1'b0;
    m_err = 1'b0; e_done = 1'b0; e_mis = 1'b0; m_accepts = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        sb.delete();
        m_free = cyc;
        win_lo = 1; win_hi = 0;
        m_err = 1'b0;
      end else if (u_if.req_valid && ((cyc - 1) >= m_free)) begin
        lvl = u_if.req_level;
        m_accepts = m_accepts + 1;
        if (lvl != q_in) begin
          win_lo = cyc; win_hi = cyc + P - 1; win_lvl = lvl;
          fq = stuck_en ? stuck_val : lvl;
          e.c = cyc + P + S; e.mis = (fq != lvl);
          m_free = e.c + 1;
        end else begin
          e.c = cyc; e.mis = 1'b0;
          m_free = cyc + 1;
        end
        sb.push_back(e);
      end
      if (sb.size() > 0 && sb[0].c == cyc) begin
        e_done = 1'b1;
        e_mis  = sb[0].mis;
        if (sb[0].mis) m_err = 1'b1;
        void'(sb.pop_front());
      end else begin
        e_done = 1'b0;
        e_mis  = 1'b0;
      end
    end
  end

  // Output monitor, sampling on the falling edge
  initial begin
    logic in_win;
    n_checks = 0; n_pass = 0; fin_done = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        in_win = (cyc >= win_lo) && (cyc <= win_hi);
        check_eq("sr_excl",    {31'd0, s & r}, 32'd0);
        check_eq("s",          {31'd0, s}, {31'd0, in_win & win_lvl});
        check_eq("r",          {31'd0, r}, {31'd0, in_win & ~win_lvl});
        check_eq("busy",       {31'd0, busy}, {31'd0, (cyc < m_free)});
        check_eq("req_ready",  {31'd0, u_if.req_ready}, {31'd0, (cyc >= m_free)});
        check_eq("done",       {31'd0, u_if.done}, {31'd0, e_done});
        check_eq("mismatch",   {31'd0, u_if.mismatch}, {31'd0, e_mis});
        check_eq("err_sticky", {31'd0, err_sticky}, {31'd0, m_err});
      end
      if (fin_req && !fin_done) begin
        check_eq("sb_empty", sb.size(), 32'd0);
        check_eq("timeouts", timeout_cnt, 32'd0);
        fin_done = 1'b1;
      end
    end
  end

  // Wait (bounded) until the next rising edge can accept a request
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cyc >= m_free) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      timeout_cnt = timeout_cnt + 1;
      $display("FAIL wait_idle cyc=%0d got=busy exp=idle", cyc);
    end
  endtask

  // Present one request for a single cycle; returns in the cycle after acceptance
  task automatic send(input logic lvl);
    @(negedge clk);
    wait_idle();
    u_if.req_valid = 1'b1;
    u_if.req_level = lvl;
    @(negedge clk);
    u_if.req_valid = 1'b0;
  endtask

  // Stimulus
  initial begin
    int target;
    rst = 1'b1; u_if.req_valid = 1'b0; u_if.req_level = 1'b0;
    stuck_en = 1'b0; stuck_val = 1'b0; glitch = 1'b0;
    timeout_cnt = 0; fin_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    send(1'b1);                 // set path, q 0 -> 1
    send(1'b1);                 // skip path
    send(1'b0);                 // reset path, q 1 -> 0

    send(1'b1);                 // set path with a readback glitch mid-settle
    repeat (3) @(negedge clk);
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;

    @(negedge clk);
    wait_idle();
    stuck_val = 1'b1; stuck_en = 1'b1;
    send(1'b0);                 // stuck flop: mismatch, err_sticky latches
    @(negedge clk);
    wait_idle();
    stuck_en = 1'b0;
    send(1'b1);                 // successful request, err stays set
    @(negedge clk);
    wait_idle();

    rst = 1'b1;                 // clears err_sticky
    repeat (2) @(negedge clk);
    rst = 1'b0;

    send(1'b0);                 // q -> 0
    send(1'b1);                 // reset mid-pulse
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Held-valid random levels: acceptances only when idle
    @(negedge clk);
    wait_idle();
    target = m_accepts + 1000;
    u_if.req_valid = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if (m_accepts >= target) break;
      u_if.req_level = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    if (m_accepts < target) begin
      timeout_cnt = timeout_cnt + 1;
      $display("FAIL random_accepts got=%0d exp=%0d", m_accepts, target);
    end
    u_if.req_valid = 1'b0;
    @(negedge clk);
    wait_idle();
    repeat (3) @(negedge clk);

    fin_req = 1'b1;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #600000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sr_cmd_driver.md
SR_CMD_DRIVER -- requirements
Module: sr_cmd_driver

Interface
REQ-001 Parameter PULSE_CYCLES, default 2, number of cycles a set or reset pulse is held; legal range 1..255.
REQ-002 Parameter SETTLE_CYCLES, default 3, number of idle cycles between pulse end and readback; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 req_valid  input  1  requester has a target level on req_level.
REQ-006 req_level  input  1  target output level for the SR flop (1 = set, 0 = reset).
REQ-007 req_ready  output  1  driver can accept a request this cycle.
REQ-008 q_in  input  1  readback of the driven SR flop's out.
REQ-009 s  output  1  set command to the SR flop, registered.
REQ-010 r  output  1  reset command to the SR flop, registered.
REQ-011 done  output  1  one-cycle completion strobe.
REQ-012 mismatch  output  1  qualified by done: readback did not equal the target.
REQ-013 err_sticky  output  1  set by any mismatch; cleared only by rst.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, PULSE, SETTLE and RESP, with an 8-bit down-counter.
REQ-016 req_ready SHALL equal (state == IDLE); a request is accepted on the edge where req_valid and req_ready are both 1, and req_level is captured then.
REQ-017 On acceptance with req_level == q_in, the FSM SHALL go directly to RESP; no s/r pulse is issued.
REQ-018 On acceptance with req_level != q_in, the FSM SHALL enter PULSE with the counter loaded to PULSE_CYCLES-1.
REQ-019 In PULSE: s = level, r = ~level for exactly PULSE_CYCLES consecutive cycles, starting the cycle after acceptance.
REQ-020 After the last PULSE cycle, the FSM SHALL enter SETTLE with the counter at SETTLE_CYCLES-1, holding s = r = 0 for exactly SETTLE_CYCLES cycles.
REQ-021 q_in SHALL be sampled on the edge that ends the last SETTLE cycle; the FSM then enters RESP.
REQ-022 RESP SHALL last one cycle, with done = 1 and mismatch = (sampled q_in != level); on the skip path mismatch = 0. The FSM then returns to IDLE.
REQ-023 s and r SHALL never both be 1 in any cycle, including across reset and state transitions.
REQ-024 s = r = 0 in IDLE, SETTLE and RESP.
REQ-025 done and mismatch SHALL be 0 outside RESP.
REQ-026 err_sticky SHALL set on the edge entering any RESP cycle that has mismatch = 1.
REQ-027 req_valid and req_level are ignored while req_ready = 0; there is no queuing.
REQ-028 Back-to-back operation: the earliest next acceptance is the IDLE cycle after RESP.
REQ-029 Latency on the pulse path: acceptance at edge T gives done high in cycle T+PULSE_CYCLES+SETTLE_CYCLES+1.
REQ-030 Latency on the skip path: acceptance at edge T gives done high in cycle T+1.
REQ-031 Changes on q_in during PULSE or SETTLE before the sample edge SHALL have no effect.

Reset
REQ-032 While rst = 1 at a rising edge, the next state SHALL be IDLE.
REQ-033 Reset values: s = 0, r = 0, done = 0, mismatch = 0, err_sticky = 0, busy = 0, counter = 0.
REQ-034 req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-035 rst in PULSE or SETTLE SHALL abort the operation: s/r low from the next cycle, no done strobe issued.

Verification (PULSE_CYCLES = 2, SETTLE_CYCLES = 3)
REQ-036 Set path: q_in = 0; req_level = 1 accepted at edge T; flop model follows s -> s = 1 in cycles T+1 and T+2; s = r = 0 in T+3..T+5; done = 1, mismatch = 0 in T+6; req_ready = 1 in T+7.
REQ-037 Skip path: q_in = 1; request level 1 -> s = r = 0 throughout; done = 1, mismatch = 0 in T+1.
REQ-038 Stuck flop: q_in held at 1; request level 0 -> r = 1 for 2 cycles; done = 1, mismatch = 1 in T+6; err_sticky = 1 and stays 1 through a following successful request until rst.
REQ-039 Reset mid-pulse: assert rst in cycle T+1 of a set -> s = 0 from T+2; no done; busy = 0; req_ready = 1 after rst deasserts.
REQ-040 Ignored requests and mutual exclusion: req_valid held high with a toggling req_level during busy -> exactly one operation per IDLE acceptance; an assertion check confirms s & r is never 1 over 1000 random requests.
